// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, state
// encodings and small op-classification helpers.
package mdu_seq_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_OP_MULLW  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULHW  = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULHWU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVW   = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVWU  = 3'd4;

  localparam logic [1:0] MDU_ST_IDLE  = 2'd0;
  localparam logic [1:0] MDU_ST_CALC  = 2'd1;
  localparam logic [1:0] MDU_ST_FIXUP = 2'd2;
  localparam logic [1:0] MDU_ST_DONE  = 2'd3;

  function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_OP_DIVW) || (op == MDU_OP_DIVWU);
  endfunction

  function automatic logic op_is_mul(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_OP_MULLW) || (op == MDU_OP_MULHW) || (op == MDU_OP_MULHWU);
  endfunction

  // MULLW goes down the signed path; its low word matches the unsigned one.
  function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_OP_MULLW) || (op == MDU_OP_MULHW) || (op == MDU_OP_DIVW);
  endfunction

endpackage

// File: rtl/mdu_seq_iter.sv
// One combinational MDU step: shift-add for multiply (LSB first) or
// restoring trial-subtract for divide (MSB first), chosen by is_div.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // acc = {hi, lo}: multiply keeps {partial product, multiplier},
  // divide keeps {remainder, dividend/quotient}.
  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_i};
    if (is_div)
      acc_o = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
               acc_i[WIDTH-2:0], ~diff[WIDTH]};
    else
      acc_o = {sum, acc_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer: IDLE -> CALC (WIDTH cycles) -> FIXUP -> DONE.
// Define MDU_FAST_MUL_EN to finish multiplies in a single CALC cycle.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mdu_start,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic [WIDTH-1:0]    mdu_a,
  input  logic [WIDTH-1:0]    mdu_b,
  input  logic [TAG_W-1:0]    mdu_rd_tag,
  input  logic                mdu_flush,
  output logic                mdu_busy,
  output logic                mdu_done,
  output logic [WIDTH-1:0]    mdu_result,
  output logic                mdu_ov,
  output logic [TAG_W-1:0]    mdu_rd_out
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MDU_OP_W-1:0]   op_q, op_d;
  logic [TAG_W-1:0]      tag_q, tag_d, rd_q, rd_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d, iter_acc, prod;
  logic [WIDTH-1:0]      opnd_q, opnd_d, res_q, res_d;
  logic [WIDTH-1:0]      abs_a, abs_b, quo, fix_res;
  logic                  neg_q, neg_d, ovf_q, ovf_d, ov_q, ov_d;
  logic                  sgn, start_div, iter_div;

  assign iter_div = op_is_div(op_q);

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div (iter_div),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (iter_acc)
  );

  // Operand magnitudes at issue, and sign/select fixup of the raw result.
  always_comb begin
    sgn       = op_is_signed(mdu_op);
    start_div = op_is_div(mdu_op);
    abs_a     = (sgn && mdu_a[WIDTH-1]) ? -mdu_a : mdu_a;
    abs_b     = (sgn && mdu_b[WIDTH-1]) ? -mdu_b : mdu_b;
    prod      = neg_q ? -acc_q : acc_q;
    quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_res   = '0;
    case (op_q)
      MDU_OP_MULLW:               fix_res = prod[WIDTH-1:0];
      MDU_OP_MULHW, MDU_OP_MULHWU: fix_res = prod[2*WIDTH-1:WIDTH];
      MDU_OP_DIVW, MDU_OP_DIVWU:   fix_res = ovf_q ? '0 : quo;
      default:                    fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    ov_d    = ov_q;
    rd_d    = rd_q;
    // Flush beats everything, including a start arriving in IDLE.
    if (mdu_flush) begin
      state_d = MDU_ST_IDLE;
    end else begin
      case (state_q)
        MDU_ST_IDLE: if (mdu_start) begin
          state_d = MDU_ST_CALC;
          cnt_d   = CNT_W'(WIDTH-1);
          op_d    = mdu_op;
          tag_d   = mdu_rd_tag;
          neg_d   = sgn && (mdu_a[WIDTH-1] ^ mdu_b[WIDTH-1]);
          ovf_d   = start_div && ((mdu_b == '0) ||
                    ((mdu_op == MDU_OP_DIVW) && (mdu_a == MIN_NEG) && (mdu_b == '1)));
          acc_d   = {{WIDTH{1'b0}}, (start_div ? abs_a : abs_b)};
          opnd_d  = start_div ? abs_b : abs_a;
        end
        MDU_ST_CALC: begin
          acc_d = iter_acc;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = MDU_ST_FIXUP;
`ifdef MDU_FAST_MUL_EN
          if (op_is_mul(op_q)) begin
            acc_d   = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
            state_d = MDU_ST_FIXUP;
          end
`endif
        end
        MDU_ST_FIXUP: begin
          state_d = MDU_ST_DONE;
          res_d   = fix_res;
          ov_d    = ovf_q;
          rd_d    = tag_q;
        end
        default: state_d = MDU_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      rd_q    <= rd_d;
    end
  end

  assign mdu_busy   = (state_q != MDU_ST_IDLE);
  assign mdu_done   = (state_q == MDU_ST_DONE);
  assign mdu_result = res_q;
  assign mdu_ov     = ov_q;
  assign mdu_rd_out = rd_q;

endmodule
